lsu: RTL and testbench

Load/store unit between the MIPS32 execute stage and the word-organised data memory. It accepts one memory request at a time over a valid/ready handshake. Byte, halfword and word loads are sign- or zero-extended. Sub-word stores are done as read-modify-write, because data memory only writes whole 32-bit words. Misaligned accesses and illegal sizes are reported as errors and never touch memory.

---
 rtl/mips_pkg.sv | 19 +
 rtl/lsu_lane.sv | 38 +++
 rtl/lsu.sv | 150 +++++++++++++++
 tb/tb_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath definitions: access size encodings, LSU states and word geometry.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_LOAD,
    LSU_STORE,
    LSU_RMW_RD,
    LSU_RMW_WR,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends load data, and merges sub-word store data into a memory word.
module lsu_lane
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Word size passes straight through; sub-word sizes select a lane and splice in the new data.
  always_comb begin
    w_byte   = i_word[{i_lane, 3'b000} +: 8];
    w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
    o_load   = i_word;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load   = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_merged = i_word;
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load   = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merged = i_word;
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MIPS32 load/store unit: one request at a time, sub-word stores as read-modify-write, misaligned accesses rejected.
module lsu
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] ADDR_MASK  = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'h1 << ADDR_BITS) - 32'h1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(WORD_BYTES) - 32'h1);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic        r_write;
  logic        r_unsigned;
  logic        r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_merged;

  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_misaligned = (req_size == 2'b11)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_ready    = (r_state == LSU_IDLE) && !rst;
  assign w_accept     = req_valid && req_ready;

  lsu_lane u_lane (
    .i_word     (mem_read_data),
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)           w_next = LSU_RESP;
          else if (!req_write)        w_next = LSU_LOAD;
          else if (req_size == SZ_WORD) w_next = LSU_STORE;
          else                        w_next = LSU_RMW_RD;
        end
      end
      LSU_LOAD, LSU_STORE, LSU_RMW_WR: w_next = LSU_RESP;
      LSU_RMW_RD:                      w_next = LSU_RMW_WR;
      default:                         w_next = LSU_IDLE;
    endcase
    if (rst) w_next = LSU_IDLE;
  end

  // Strobes and response are gated by reset so an aborted store never reaches memory.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    case (r_state)
      LSU_LOAD, LSU_RMW_RD: begin
        mem_read = !rst;
        mem_addr = r_addr & ALIGN_MASK;
      end
      LSU_STORE: begin
        mem_write      = !rst;
        mem_addr       = r_addr & ALIGN_MASK;
        mem_write_data = r_wdata;
      end
      LSU_RMW_WR: begin
        mem_write      = !rst;
        mem_addr       = r_addr & ALIGN_MASK;
        mem_write_data = r_merged;
      end
      LSU_RESP: begin
        resp_valid = !rst;
        resp_err   = r_err && !rst;
        resp_rdata = rst ? 32'h0 : r_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_merged   <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_addr     <= req_addr & ADDR_MASK;
            r_wdata    <= req_wdata;
            r_err      <= w_misaligned;
            r_rdata    <= '0;
          end
        end
        LSU_LOAD:   r_rdata  <= w_load;
        LSU_RMW_RD: r_merged <= w_merged;
        default: ;
      endcase
    end
  end

  logic w_unusedWrite;
  assign w_unusedWrite = r_write;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized traffic against a byte-level memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] refMem [0:1023];
  logic        loadImage;

  lsu #(.ADDR_BITS(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write committed on the rising edge; preloaded from the model image.
  assign mem_read_data = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (loadImage) begin
      for (int i = 0; i < 1024; i++) mem[i] <= refMem[i];
    end else if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_write_data;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches the DUT until its response, recording latency and protocol breaches.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output logic er, output int lat,
                               output int wrs, output int viol);
    int  guard;
    bit  found;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!req_ready) checkOutput("readyTimeout", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom; req_wdata = $urandom;
    rd = '0; er = 1'b0; lat = -1; wrs = 0; viol = 0; found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      #1;
      if (mem_write) wrs++;
      if (req_ready) viol++;
      if (mem_read && mem_write) viol++;
      if (!(mem_read || mem_write) && (mem_addr != 0 || mem_write_data != 0)) viol++;
      if (mem_addr[31:12] != 0 || mem_addr[1:0] != 0) viol++;
      if (resp_valid) begin
        found = 1'b1; lat = c; rd = resp_rdata; er = resp_err;
      end else if (resp_rdata != 0 || resp_err) begin
        viol++;
      end
      if (!found) @(negedge clk);
    end
  endtask

  // Computes the expected outcome from byte-lane arithmetic on the model image, then runs and checks the request.
  task automatic runTxn(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    logic        expErr, er;
    logic [31:0] word, mask, v, expRd;
    int          idx, sh, expLat, expWrs, lat, wrs, viol;
    expErr = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    idx    = int'(a[11:2]);
    word   = refMem[idx];
    sh     = int'(a[1:0]) * 8;
    mask   = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    expRd  = '0;
    if (!expErr && !w) begin
      v = (word >> sh) & mask;
      if (!u && sz != 2'b10 && (v & ((mask >> 1) + 32'h1)) != 0) v = v | ~mask;
      expRd = v;
    end
    if (!expErr && w) refMem[idx] = (word & ~(mask << sh)) | ((d & mask) << sh);
    expLat = expErr ? 1 : (w && sz != 2'b10) ? 3 : 2;
    expWrs = (w && !expErr) ? 1 : 0;
    applyStimulus(w, sz, u, a, d, rd, er, lat, wrs, viol);
    checkOutput("latency",  32'(lat),  32'(expLat));
    checkOutput("err",      32'(er),   32'(expErr));
    checkOutput("rdata",    rd,        expRd);
    checkOutput("writes",   32'(wrs),  32'(expWrs));
    checkOutput("protocol", 32'(viol), 32'h0);
    if (w) checkOutput("memWord", mem[idx], refMem[idx]);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] b2bData [0:3];
    int          b2bCyc  [0:3];
    int          nResp, nWr, diffs, guard;
    logic        readyAt3;

    rst = 1'b1; loadImage = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = $urandom;
    refMem[0] = 32'hDEADBEEF; refMem[1] = 32'hCAFEBABE; refMem[2] = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rstReady",  32'(req_ready),  32'h0);
    checkOutput("rstValid",  32'(resp_valid), 32'h0);
    checkOutput("rstRead",   32'(mem_read),   32'h0);
    checkOutput("rstWrite",  32'(mem_write),  32'h0);
    rst = 1'b0; loadImage = 1'b0;
    #1;
    checkOutput("postRstReady", 32'(req_ready), 32'h1);
    checkOutput("postRstRdata", resp_rdata,     32'h0);
    checkOutput("postRstAddr",  mem_addr,       32'h0);

    runTxn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd);
    checkOutput("t1Word", rd, 32'hCAFEBABE);
    runTxn(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, rd);
    checkOutput("t2Signed", rd, 32'hFFFFFFDE);
    runTxn(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, rd);
    checkOutput("t2Unsigned", rd, 32'h000000DE);

    // Back-to-back word loads with req_valid held high; the address changes while the unit is busy.
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); #1; guard++; end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0;
    nResp = 0; readyAt3 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (c == 3) readyAt3 = req_ready;
      if (resp_valid) begin
        if (nResp < 4) begin b2bData[nResp] = resp_rdata; b2bCyc[nResp] = c; end
        nResp++;
      end
      if (c == 1) req_addr = 32'h8;
      if (c == 4) req_valid = 1'b0;
    end
    checkOutput("b2bCount", 32'(nResp), 32'h2);
    checkOutput("b2bReady", 32'(readyAt3), 32'h1);
    if (nResp >= 2) begin
      checkOutput("b2bCyc0",  32'(b2bCyc[0]), 32'h2);
      checkOutput("b2bCyc1",  32'(b2bCyc[1]), 32'h5);
      checkOutput("b2bData0", b2bData[0], 32'hDEADBEEF);
      checkOutput("b2bData1", b2bData[1], 32'h12345678);
    end

    runTxn(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000A55A, rd);
    runTxn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd);
    checkOutput("t3Merged", rd, 32'hA55A5678);

    runTxn(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, rd);
    runTxn(1'b1, 2'b10, 1'b0, 32'h6, 32'h11223344, rd);
    checkOutput("t4Word1", mem[1], 32'hCAFEBABE);

    // Reset lands while the byte store is in its write phase; nothing may be written or answered.
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); #1; guard++; end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h00000011;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("rmwWrPhase", 32'(mem_write), 32'h1);
    rst = 1'b1; #1;
    checkOutput("abortWrite", 32'(mem_write), 32'h0);
    checkOutput("abortReady", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0; #1;
    checkOutput("readyAfterRst", 32'(req_ready), 32'h1);
    nResp = 0; nWr = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) nResp++;
      if (mem_write) nWr++;
      @(negedge clk); #1;
    end
    checkOutput("abortResp",   32'(nResp), 32'h0);
    checkOutput("abortWrites", 32'(nWr),   32'h0);
    checkOutput("abortWord0",  mem[0],     32'hDEADBEEF);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom & (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'hF000_003F);
      runTxn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, rd);
    end

    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== refMem[i]) diffs++;
    checkOutput("memImage", 32'(diffs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
